// File: rtl/hazard_unit_pkg.sv
// Shared types and defaults for the pipeline interlock controller.
// Holds the FSM state type and default sizing constants.
package hazard_unit_pkg;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hazard_state_t;

  localparam int unsigned HZ_MEM_TIMEOUT = 16;
  localparam int unsigned HZ_CNT_W       = 32;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating event counter: adds one per cycle while inc is high,
// sticks at all-ones. Ports: clk, rst, inc, count[W-1:0].
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline interlock: memory freeze, branch squash, load-use bubble.
// In: ID/EX hazard info, mem req/ready. Out: stalls, bubbles, flush, counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = HZ_MEM_TIMEOUT,
  parameter int unsigned CNT_W       = HZ_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_sel_rs1_i,
  input  logic [4:0]       id_sel_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       ex_sel_rd_i,
  input  logic             ex_is_load_i,
  input  logic             ex_branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_ex_o,
  output logic             stall_mem_o,
  output logic             bubble_ex_o,
  output logic             bubble_wb_o,
  output logic             flush_id_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WMAX = WCW'(MEM_TIMEOUT);

  hazard_state_t  state_q;
  logic [WCW-1:0] wcnt_q;

  logic at_limit;
  logic in_run;
  logic in_wait;
  logic freeze;
  logic timeout;
  logic branch;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic live;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  assign at_limit = (wcnt_q == WMAX);
  assign in_run   = (state_q == HZ_RUN);
  assign in_wait  = (state_q == HZ_MEM_WAIT);

  assign freeze  = (in_run && mem_req_i && !mem_ready_i)
                || (in_wait && !mem_ready_i && !at_limit);
  // A ready in the final wait cycle wins over the timeout.
  assign timeout = in_wait && !mem_ready_i && at_limit;

  assign rs1_hit = id_uses_rs1_i && (id_sel_rs1_i == ex_sel_rd_i);
  assign rs2_hit = id_uses_rs2_i && (id_sel_rs2_i == ex_sel_rd_i);

  assign branch   = !freeze && ex_branch_taken_i;
  assign load_use = !freeze && !ex_branch_taken_i && ex_is_load_i
                 && (ex_sel_rd_i != 5'd0) && (rs1_hit || rs2_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HZ_RUN;
      wcnt_q  <= '0;
    end else begin
      unique case (state_q)
        HZ_RUN: begin
          if (mem_req_i && !mem_ready_i) begin
            state_q <= HZ_MEM_WAIT;
            wcnt_q  <= '0;
          end
        end
        HZ_MEM_WAIT: begin
          if (mem_ready_i || at_limit) begin
            state_q <= HZ_RUN;
          end else begin
            wcnt_q <= wcnt_q + WCW'(1);
          end
        end
      endcase
    end
  end

  // Every output is held low for the whole reset cycle.
  assign live = !rst;

  assign stall_if_o    = live && (freeze || load_use);
  assign stall_id_o    = live && (freeze || load_use);
  assign stall_ex_o    = live && freeze;
  assign stall_mem_o   = live && freeze;
  assign bubble_ex_o   = live && (branch || load_use);
  assign bubble_wb_o   = live && freeze;
  assign flush_id_o    = live && branch;
  assign mem_timeout_o = live && timeout;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_if_o),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_id_o),
    .count (flush_cnt)
  );

  assign stall_cycles_o = live ? stall_cnt : '0;
  assign flush_count_o  = live ? flush_cnt : '0;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with a rule-level reference model.
// Model checked every cycle, plus literal spot checks.
module tb_hazard_unit;

  localparam int MT = 4;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1, rs2, rd;
  logic        u1, u2, ld, tk, req, rdy;
  logic        s_if, s_id, s_ex, s_mem, b_ex, b_wb, fl, tmo;
  logic [31:0] scyc, fcnt;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_unit #(.MEM_TIMEOUT(MT), .CNT_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .id_sel_rs1_i      (rs1),
    .id_sel_rs2_i      (rs2),
    .id_uses_rs1_i     (u1),
    .id_uses_rs2_i     (u2),
    .ex_sel_rd_i       (rd),
    .ex_is_load_i      (ld),
    .ex_branch_taken_i (tk),
    .mem_req_i         (req),
    .mem_ready_i       (rdy),
    .stall_if_o        (s_if),
    .stall_id_o        (s_id),
    .stall_ex_o        (s_ex),
    .stall_mem_o       (s_mem),
    .bubble_ex_o       (b_ex),
    .bubble_wb_o       (b_wb),
    .flush_id_o        (fl),
    .mem_timeout_o     (tmo),
    .stall_cycles_o    (scyc),
    .flush_count_o     (fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: are we waiting on memory, and for how many
  // cycles have we already waited; plus running event totals.
  bit m_wait    = 0;
  int m_waited  = 0;
  int m_stalls  = 0;
  int m_flushes = 0;

  // {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb,
  //  flush_id, mem_timeout}
  function automatic logic [7:0] model_ctrl();
    bit frz, to, br, lu, hit;
    if (rst) return 8'h00;
    frz = (!m_wait && req && !rdy) || (m_wait && !rdy && m_waited < MT);
    to  = m_wait && !rdy && m_waited == MT;
    br  = !frz && tk;
    hit = (u1 && rs1 == rd) || (u2 && rs2 == rd);
    lu  = !frz && !tk && ld && rd != 0 && hit;
    return {frz | lu, frz | lu, frz, frz, br | lu, frz, br, to};
  endfunction

  always @(posedge clk) begin
    logic [7:0] e;
    e = model_ctrl();
    if (rst) begin
      m_wait = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (e[7]) m_stalls++;
      if (e[1]) m_flushes++;
      if (!m_wait) begin
        if (req && !rdy) begin m_wait = 1; m_waited = 0; end
      end else if (rdy || m_waited == MT) begin
        m_wait = 0;
      end else begin
        m_waited++;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e, g;
    logic [31:0] es, ef;
    e  = model_ctrl();
    g  = {s_if, s_id, s_ex, s_mem, b_ex, b_wb, fl, tmo};
    es = rst ? 32'd0 : 32'(m_stalls);
    ef = rst ? 32'd0 : 32'(m_flushes);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL ctrl t=%0t got=%b want=%b", $time, g, e);
    end
    n_cmp++;
    if (scyc !== es || fcnt !== ef) begin
      n_bad++;
      $display("FAIL cnt t=%0t got=%0d/%0d want=%0d/%0d",
               $time, scyc, fcnt, es, ef);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0;
    ld = 0; tk = 0; req = 0; rdy = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    req = 1; tk = 1;
    #1;
    chk("rst_stall", {31'd0, s_if}, 0);
    chk("rst_flush", {31'd0, fl}, 0);
    nxt(); rst = 0; idle(); #1;
    chk("idle_stall", {31'd0, s_if}, 0);
    chk("idle_cnt", scyc, 0);

    // load x5, ID reads rs2=x5
    nxt(); ld = 1; rd = 5; u2 = 1; rs2 = 5; #1;
    chk("lu_stall_if", {31'd0, s_if}, 1);
    chk("lu_bubble", {31'd0, b_ex}, 1);
    chk("lu_stall_ex", {31'd0, s_ex}, 0);
    nxt(); idle(); #1;
    chk("lu_clear", {31'd0, s_if}, 0);
    chk("lu_cnt", scyc, 1);

    // x0 and unused source
    nxt(); ld = 1; rd = 0; u1 = 1; rs1 = 0; #1;
    chk("x0_nostall", {31'd0, s_if}, 0);
    nxt(); idle(); ld = 1; rd = 3; rs1 = 3; u1 = 0; #1;
    chk("unused_nostall", {31'd0, s_if}, 0);

    // 3-cycle memory wait
    nxt(); idle(); req = 1; #1;
    chk("mw_frz0", {31'd0, s_mem}, 1);
    chk("mw_bwb0", {31'd0, b_wb}, 1);
    nxt(); #1;
    chk("mw_frz1", {31'd0, s_mem}, 1);
    nxt(); #1;
    chk("mw_frz2", {31'd0, s_mem}, 1);
    nxt(); rdy = 1; #1;
    chk("mw_ready", {31'd0, s_mem}, 0);
    nxt(); idle(); #1;
    chk("mw_run", {31'd0, s_if}, 0);
    chk("mw_cnt", scyc, 4);

    // timeout
    nxt(); req = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("to_frz", {31'd0, s_if}, 1);
      chk("to_nopulse", {31'd0, tmo}, 0);
      nxt();
    end
    #1;
    chk("to_pulse", {31'd0, tmo}, 1);
    chk("to_release", {31'd0, s_if}, 0);
    chk("to_cnt", scyc, 9);
    nxt(); idle(); #1;
    chk("to_once", {31'd0, tmo}, 0);

    // branch under freeze
    nxt(); req = 1; tk = 1; #1;
    chk("bf_noflush0", {31'd0, fl}, 0);
    chk("bf_stall0", {31'd0, s_if}, 1);
    nxt(); #1;
    chk("bf_noflush1", {31'd0, fl}, 0);
    nxt(); rdy = 1; #1;
    chk("bf_flush", {31'd0, fl}, 1);
    chk("bf_bubble", {31'd0, b_ex}, 1);
    chk("bf_nostall", {31'd0, s_if}, 0);
    nxt(); idle(); #1;
    chk("bf_fcnt", fcnt, 1);
    chk("bf_scnt", scyc, 11);

    // branch and load-use together
    nxt(); tk = 1; ld = 1; rd = 7; rs1 = 7; u1 = 1; #1;
    chk("blu_flush", {31'd0, fl}, 1);
    chk("blu_bubble", {31'd0, b_ex}, 1);
    chk("blu_nostall", {31'd0, s_if}, 0);
    nxt(); idle(); #1;
    chk("blu_fcnt", fcnt, 2);

    // reset while waiting
    nxt(); req = 1; #1;
    nxt(); #1;
    chk("rw_wait", {31'd0, s_if}, 1);
    nxt(); rst = 1; tk = 1; ld = 1; rd = 2; rs2 = 2; u2 = 1; #1;
    chk("rw_rst_stall", {31'd0, s_if}, 0);
    chk("rw_rst_flush", {31'd0, fl}, 0);
    chk("rw_rst_scnt", scyc, 0);
    chk("rw_rst_fcnt", fcnt, 0);
    nxt(); rst = 0; idle(); #1;
    chk("rw_run", {31'd0, s_if}, 0);
    chk("rw_scnt", scyc, 0);
    chk("rw_fcnt", fcnt, 0);
    nxt(); nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline interlock controller for the 5-stage core.
- Issues the stall, bubble and flush controls that forwarding cannot cover:
  - load-use hazards
  - taken-branch squash
  - multi-cycle data-memory waits, with a timeout
- Sits beside the forwarding logic and drives the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline register enables and clears.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- MEM_TIMEOUT, 16: maximum MEM_WAIT cycles before the wait is abandoned. Must be ≥1.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- id_sel_rs1_i  in  5  rs1 pointer of the instruction in ID
- id_sel_rs2_i  in  5  rs2 pointer of the instruction in ID
- id_uses_rs1_i  in  1  the ID instruction reads rs1
- id_uses_rs2_i  in  1  the ID instruction reads rs2
- ex_sel_rd_i  in  5  rd pointer of the instruction in EX
- ex_is_load_i  in  1  the EX instruction is a load
- ex_branch_taken_i  in  1  the EX instruction redirects the PC
- mem_req_i  in  1  the MEM stage has a valid data-memory access
- mem_ready_i  in  1  data memory completes the access this cycle
- stall_if_o  out  1  hold PC and IF/ID
- stall_id_o  out  1  hold ID/EX
- stall_ex_o  out  1  hold EX/MEM
- stall_mem_o  out  1  hold MEM/WB input side
- bubble_ex_o  out  1  load NOP into ID/EX
- bubble_wb_o  out  1  load NOP into MEM/WB
- flush_id_o  out  1  clear IF/ID
- mem_timeout_o  out  1  one-cycle pulse when the memory wait expires
- stall_cycles_o  out  CNT_W  count of cycles with stall_if_o high
- flush_count_o  out  CNT_W  count of cycles with flush_id_o high

Behaviour:
- Only the clock and reset above are used: one clock; reset is synchronous and active-high.
- State machine, two states, reset state RUN:
  - RUN: normal operation.
  - MEM_WAIT: waiting on data memory.
- RUN → MEM_WAIT when mem_req_i=1 and mem_ready_i=0.
- MEM_WAIT → RUN when mem_ready_i=1, or when wait_cnt==MEM_TIMEOUT.
- wait_cnt:
  - Cleared on entry to MEM_WAIT.
  - Increments each cycle spent in MEM_WAIT.
  - Width is clog2(MEM_TIMEOUT+1).
- Memory freeze (highest priority), decoded combinationally:
  - Active when (RUN & mem_req_i & !mem_ready_i), or (MEM_WAIT & !mem_ready_i & wait_cnt!=MEM_TIMEOUT).
  - Drives stall_if/id/ex/mem=1 and bubble_wb=1.
  - Forces flush_id=0 and bubble_ex=0. The branch and load stay in place and are re-evaluated after the freeze.
- Timeout: in MEM_WAIT with wait_cnt==MEM_TIMEOUT and mem_ready_i=0:
  - mem_timeout_o=1 for that cycle.
  - Freeze releases and the next state is RUN.
  - mem_ready_i=1 in the same cycle takes precedence: no timeout pulse.
- Branch flush (second priority, only when not frozen): ex_branch_taken_i=1 gives flush_id=1 and bubble_ex=1, with all stalls 0.
- Load-use (third priority, only when not frozen and no flush):
  - Condition: ex_is_load_i, ex_sel_rd_i≠0, and (id_uses_rs1_i & rs1==rd) or (id_uses_rs2_i & rs2==rd).
  - Response: stall_if=1, stall_id=1, bubble_ex=1 for exactly that cycle.
  - The next cycle the load has advanced to MEM, so the condition clears naturally. A single-cycle bubble is required.
- An x0 source never causes a stall.
- All control outputs are combinational from state, counters and inputs, giving zero-cycle latency.
- While rst=1 every output is 0.
- Performance counters:
  - Registered; increment on the cycle after the qualifying output is high.
  - Saturate at all-ones.
  - Reset to 0.
- Reset mid-wait: state returns to RUN, and wait_cnt and both counters clear on the next edge.

Decomposition:
- Shared core package holds:
  - hazard_state_t enum {HZ_RUN, HZ_MEM_WAIT}
  - the default MEM_TIMEOUT constant
- Sub-module sat_counter (parameter W; ports inc, count) is instantiated twice for the performance counters.

Test Plan:
- Load x5 in EX, ID add reads rs2=x5 (uses_rs2=1) → one cycle of stall_if=stall_id=bubble_ex=1; next cycle all 0; stall_cycles_o=1.
- Load rd=x0 with ID rs1=x0 → no stall. Load rd=x3, ID rs1=x3 but uses_rs1=0 → no stall.
- mem_req=1, mem_ready low 3 cycles then high → freeze high for the first 3 cycles, 0 on the ready cycle; state back to RUN; stall_cycles_o=3.
- MEM_TIMEOUT=4, mem_ready never high → freeze for 5 cycles (1 in RUN plus wait_cnt 0..3), then mem_timeout_o pulses once with freeze released.
- Branch taken during a memory freeze → flush_id=0 while frozen; flush_id=bubble_ex=1 on the ready cycle; flush_count_o=1.
- Branch taken and load-use together → only flush_id/bubble_ex asserted, stall_if=0. Assert rst in MEM_WAIT → all outputs 0, counters 0.
